sram_port_ctrl: RTL and testbench
=================================

Name: sram_port_ctrl

Overview:
- Single-port asynchronous SRAM access controller that sits directly downstream of the memory test sequencer and owns one RAM chip's pins.
- Accepts one read or write request at a time over a ready/req handshake.
- Generates glitch-free CE/OE/WE strobes with setup/pulse/hold phases and returns read data with a one-cycle valid pulse.
- Instantiated once per RAM chip (ram1, ram2).

Parameters:
- WR_CYCLES, 2, number of clock cycles WE_n is held low (legal 1..15)
- RD_CYCLES, 2, number of clock cycles OE_n is low before the data bus is sampled (legal 1..15)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  1  request strobe; sampled only when ready=1
- we  in  1  1=write, 0=read; sampled with req
- addr  in  16  word address; sampled with req
- wdata  in  16  write data; sampled with req
- ready  out  1  controller idle and able to accept req
- rdata  out  16  read data; holds last read value
- rvalid  out  1  one-cycle pulse, rdata newly valid
- ram_addr  out  16  SRAM address pins
- ram_data  inout  16  SRAM data bus
- ram_ce_n  out  1  chip enable, active low
- ram_oe_n  out  1  output enable, active low
- ram_we_n  out  1  write enable, active low

Behaviour:
- Reset (async, rst=0): state IDLE, ready=1, rvalid=0, rdata=0, ram_addr=0, ram_ce_n=1, ram_oe_n=1, ram_we_n=1, ram_data released (high-Z), phase counter=0. Any in-flight access is abandoned; strobes deassert immediately, not at the next edge.
- All pin outputs are driven from registers; no strobe is derived combinationally from clk.
- States:
  - IDLE: ready=1, ce_n=1, oe_n=1, we_n=1, bus high-Z. On edge with req=1, latch addr/wdata/we and set ready=0. Go to WR_SETUP if we=1, else RD_WAIT.
  - WR_SETUP (1 cycle): ce_n=0, we_n=1, ram_addr=latched addr, bus driven with latched wdata. Go to WR_PULSE.
  - WR_PULSE (WR_CYCLES cycles): we_n=0; address and data stable. Go to WR_HOLD.
  - WR_HOLD (1 cycle): we_n=1, data still driven, ce_n=0. Go to IDLE; ce_n=1, bus released, ready=1.
  - RD_WAIT (RD_CYCLES cycles): ce_n=0, oe_n=0, bus high-Z. At the edge ending the last cycle, rdata <= ram_data, rvalid <= 1, oe_n <= 1, ce_n <= 1. Go to IDLE.
- Latency, with request accepted at edge N:
  - Write: ready returns high after edge N+WR_CYCLES+2.
  - Read: rvalid=1 and ready=1 in the same cycle, after edge N+RD_CYCLES. rvalid deasserts after exactly one cycle.
- Bus safety: ram_data is driven only in WR_SETUP, WR_PULSE and WR_HOLD. The controller never drives the bus in any cycle where oe_n=0. we_n=0 and oe_n=0 are never asserted simultaneously.
- The phase counter is 4 bits. It counts from 0 to (CYCLES-1) within a phase and clears on every phase change.
- req while ready=0 is ignored; it is neither queued nor latched. The requester must hold req until it observes ready=1.
- Back-to-back: if req=1 in the cycle rvalid=1 (ready=1), the next access is accepted at that edge. No idle bubble is required.
- addr/wdata/we changes after acceptance have no effect on the access in flight.

Decomposition:
- Shared package memory_pkg:
  - state encoding constants (ST_IDLE=3'd0, ST_WR_SETUP=3'd1, ST_WR_PULSE=3'd2, ST_WR_HOLD=3'd3, ST_RD_WAIT=3'd4)
  - data/address width constants (16)
- No sub-module in RTL: the tri-state is a single continuous assign on an internal drive-enable.
- The bench supplies a behavioural async-SRAM model, sram_model, with 64K x 16 storage that checks WE/OE overlap.

Test Plan:
- Reset: rst=0 mid-WR_PULSE → within the same cycle ram_we_n=1, ram_ce_n=1, bus high-Z; after release ready=1, rdata=0x0000.
- Write then read, defaults: write addr=0x0012 data=0xA55A, then read 0x0012 → we_n low exactly 2 cycles; rvalid pulse 2 cycles after read accept; rdata=0xA55A.
- Parameter sweep WR_CYCLES=1/RD_CYCLES=1 and 15/15: 16 writes of data=0x1000+i to addr=0x0100+i, then readback → all match; we_n low width equals WR_CYCLES every time.
- Back-to-back: req held high with alternating read/write over 8 accesses → each accepted on the first ready cycle; no WE/OE overlap flagged; bus never driven with oe_n=0.
- Ignored req: pulse req with addr=0xFFFF during a write in flight → no extra access occurs and memory at 0xFFFF is unchanged.
- Input stability: change addr/wdata one cycle after acceptance of a write to 0x0020/0x1234 → memory[0x0020]=0x1234 and the new values are not written.

Source files
------------

// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared widths and FSM state encoding for the SRAM port controller
package memory_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_SETUP = 3'd1,
        ST_WR_PULSE = 3'd2,
        ST_WR_HOLD  = 3'd3,
        ST_RD_WAIT  = 3'd4
    } state_t;

endpackage

// File: rtl/sram_port_ctrl_if.sv
// rtl/sram_port_ctrl_if.sv - request/response handshake between test sequencer and SRAM port
interface sram_port_ctrl_if;
    import memory_pkg::*;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (output req, we, addr, wdata, input  ready, rdata, rvalid);
    modport slave  (input  req, we, addr, wdata, output ready, rdata, rvalid);

endinterface

// File: rtl/sram_port_ctrl.sv
// rtl/sram_port_ctrl.sv - async SRAM access controller with registered CE/OE/WE strobes
module sram_port_ctrl
    import memory_pkg::*;
#(
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    sram_port_ctrl_if.slave   bus,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    localparam logic [3:0] WR_LAST = 4'(WR_CYCLES - 1);
    localparam logic [3:0] RD_LAST = 4'(RD_CYCLES - 1);

    state_t            r_state, w_state;
    logic [3:0]        r_cnt, w_cnt;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [DATA_W-1:0] r_wdata, w_wdata;
    logic [DATA_W-1:0] r_rdata, w_rdata;
    logic              r_rvalid, w_rvalid;
    logic              r_ready, w_ready;
    logic              r_ce_n, w_ce_n;
    logic              r_oe_n, w_oe_n;
    logic              r_we_n, w_we_n;
    logic              r_drive, w_drive;

    // Async reset drops every strobe and releases the bus without waiting for an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_ready  <= 1'b1;
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_drive  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_rdata  <= w_rdata;
            r_rvalid <= w_rvalid;
            r_ready  <= w_ready;
            r_ce_n   <= w_ce_n;
            r_oe_n   <= w_oe_n;
            r_we_n   <= w_we_n;
            r_drive  <= w_drive;
        end
    end

    // Next values are the strobe levels for the state being entered, so pins stay registered.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_addr   = r_addr;
        w_wdata  = r_wdata;
        w_rdata  = r_rdata;
        w_rvalid = 1'b0;
        w_ready  = r_ready;
        w_ce_n   = r_ce_n;
        w_oe_n   = r_oe_n;
        w_we_n   = r_we_n;
        w_drive  = r_drive;
        case (r_state)
            ST_IDLE: begin
                if (bus.req) begin
                    w_addr  = bus.addr;
                    w_wdata = bus.wdata;
                    w_ready = 1'b0;
                    w_ce_n  = 1'b0;
                    w_cnt   = 4'd0;
                    if (bus.we) begin
                        w_state = ST_WR_SETUP;
                        w_drive = 1'b1;
                    end else begin
                        w_state = ST_RD_WAIT;
                        w_oe_n  = 1'b0;
                    end
                end
            end
            ST_WR_SETUP: begin
                w_state = ST_WR_PULSE;
                w_we_n  = 1'b0;
            end
            ST_WR_PULSE: begin
                if (r_cnt == WR_LAST) begin
                    w_state = ST_WR_HOLD;
                    w_we_n  = 1'b1;
                    w_cnt   = 4'd0;
                end else begin
                    w_cnt = r_cnt + 4'd1;
                end
            end
            ST_WR_HOLD: begin
                w_state = ST_IDLE;
                w_ce_n  = 1'b1;
                w_drive = 1'b0;
                w_ready = 1'b1;
            end
            ST_RD_WAIT: begin
                if (r_cnt == RD_LAST) begin
                    w_state  = ST_IDLE;
                    w_cnt    = 4'd0;
                    w_rdata  = ram_data;
                    w_rvalid = 1'b1;
                    w_oe_n   = 1'b1;
                    w_ce_n   = 1'b1;
                    w_ready  = 1'b1;
                end else begin
                    w_cnt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_cnt   = 4'd0;
                w_ready = 1'b1;
                w_ce_n  = 1'b1;
                w_oe_n  = 1'b1;
                w_we_n  = 1'b1;
                w_drive = 1'b0;
            end
        endcase
    end

    assign ram_data   = r_drive ? r_wdata : {DATA_W{1'bz}};
    assign ram_addr   = r_addr;
    assign ram_ce_n   = r_ce_n;
    assign ram_oe_n   = r_oe_n;
    assign ram_we_n   = r_we_n;
    assign bus.ready  = r_ready;
    assign bus.rdata  = r_rdata;
    assign bus.rvalid = r_rvalid;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb/tb_sram_port_ctrl.sv - self-checking bench: three controllers (2/2, 1/1, 15/15) on SRAM models
module tb_sram_port_ctrl;
    import memory_pkg::*;

    localparam int NI = 3;

    function automatic int cyc(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 15;
    endfunction

    function automatic logic [15:0] init_pat(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_a   [NI];
    logic        we_a    [NI];
    logic [15:0] addr_a  [NI];
    logic [15:0] wdata_a [NI];
    wire         ready_a [NI];
    wire         rvalid_a[NI];
    wire         ce_a    [NI];
    wire         oe_a    [NI];
    wire         wen_a   [NI];
    wire  [15:0] rdata_a [NI];
    wire  [15:0] raddr_a [NI];
    wire  [15:0] bus_a   [NI];
    logic [15:0] mem [NI][65536];

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        sram_port_ctrl_if u_if ();
        wire [15:0] ram_data;
        wire [15:0] ram_addr;
        wire        ce_n, oe_n, we_n;

        assign u_if.req   = req_a[g];
        assign u_if.we    = we_a[g];
        assign u_if.addr  = addr_a[g];
        assign u_if.wdata = wdata_a[g];
        assign ready_a[g]  = u_if.ready;
        assign rvalid_a[g] = u_if.rvalid;
        assign rdata_a[g]  = u_if.rdata;
        assign ce_a[g]     = ce_n;
        assign oe_a[g]     = oe_n;
        assign wen_a[g]    = we_n;
        assign raddr_a[g]  = ram_addr;
        assign bus_a[g]    = ram_data;
        assign ram_data = (!ce_n && !oe_n && we_n) ? mem[g][ram_addr] : 16'bz;

        sram_port_ctrl #(.WR_CYCLES(cyc(g)), .RD_CYCLES(cyc(g))) u_dut (
            .clk      (clk),
            .rst      (rst_n),
            .bus      (u_if),
            .ram_addr (ram_addr),
            .ram_data (ram_data),
            .ram_ce_n (ce_n),
            .ram_oe_n (oe_n),
            .ram_we_n (we_n)
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // SRAM model: stores on the rising edge of WE_n while selected; also polices strobe overlap and WE width.
    int   lowcnt [NI];
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (!wen_a[k] || !oe_a[k])
                check($sformatf("we_oe_overlap[%0d]", k), 32'(!wen_a[k] && !oe_a[k]), 32'd0);
            if (!wen_a[k]) begin
                lowcnt[k]++;
            end else begin
                if (lowcnt[k] != 0 && !ce_a[k] && rst_n) begin
                    check($sformatf("we_n_low_width[%0d]", k), lowcnt[k], cyc(k));
                    mem[k][raddr_a[k]] = bus_a[k];
                end
                lowcnt[k] = 0;
            end
        end
    end

    task automatic wait_ready(input int k, inout int t);
        while (!ready_a[k] && t < 100) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic access(input int k, input bit w, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp);
        int t;
        t = 0;
        wait_ready(k, t);
        req_a[k] = 1'b1; we_a[k] = w; addr_a[k] = a; wdata_a[k] = d;
        @(negedge clk);
        req_a[k] = 1'b0;
        t = 1;
        if (w) begin
            wait_ready(k, t);
            check($sformatf("write_latency[%0d]", k), t, cyc(k) + 3);
        end else begin
            while (!rvalid_a[k] && t < 100) begin
                @(negedge clk);
                t++;
            end
            check($sformatf("read_latency[%0d]", k), t, cyc(k) + 1);
            check($sformatf("ready_with_rvalid[%0d]", k), ready_a[k], 1);
            check($sformatf("rdata[%0d]@%0h", k, a), rdata_a[k], exp);
            @(negedge clk);
            check($sformatf("rvalid_one_cycle[%0d]", k), rvalid_a[k], 0);
        end
    endtask

    typedef struct {
        int          inst;
        bit          w;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [8];
        logic [15:0] sb [int];
        int          t, ce_low;
        bit          prev_w;
        logic [15:0] prev_a;

        tbl[0] = '{0, 1'b1, 16'h0012, 16'hA55A, 16'h0000};
        tbl[1] = '{0, 1'b0, 16'h0012, 16'h0000, 16'hA55A};
        tbl[2] = '{0, 1'b0, 16'h0013, 16'h0000, 16'h5A49};
        tbl[3] = '{1, 1'b1, 16'hFFFE, 16'hC3C3, 16'h0000};
        tbl[4] = '{1, 1'b0, 16'hFFFE, 16'h0000, 16'hC3C3};
        tbl[5] = '{2, 1'b1, 16'h0000, 16'h0001, 16'h0000};
        tbl[6] = '{2, 1'b0, 16'h0000, 16'h0000, 16'h0001};
        tbl[7] = '{0, 1'b0, 16'h8000, 16'h0000, 16'hDA5A};

        for (int k = 0; k < NI; k++) begin
            req_a[k] = 1'b0; we_a[k] = 1'b0; addr_a[k] = '0; wdata_a[k] = '0; lowcnt[k] = 0;
            for (int a = 0; a < 65536; a++) mem[k][a] = init_pat(16'(a));
        end

        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_ready[%0d]", k), ready_a[k], 1);
            check($sformatf("rst_rvalid[%0d]", k), rvalid_a[k], 0);
            check($sformatf("rst_rdata[%0d]", k), rdata_a[k], 0);
            check($sformatf("rst_ram_addr[%0d]", k), raddr_a[k], 0);
            check($sformatf("rst_strobes[%0d]", k), {ce_a[k], oe_a[k], wen_a[k]}, 3'b111);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            access(tbl[i].inst, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp);

        // Back-to-back with req held: write/read pairs on the same address.
        req_a[0] = 1'b1;
        prev_w = 1'b0; prev_a = '0;
        t = 0;
        for (int j = 0; j < 9; j++) begin
            wait_ready(0, t);
            if (j > 0) begin
                check($sformatf("b2b_gap[%0d]", j), t, prev_w ? cyc(0) + 3 : cyc(0) + 1);
                if (!prev_w) begin
                    check($sformatf("b2b_rvalid[%0d]", j), rvalid_a[0], 1);
                    check($sformatf("b2b_rdata[%0d]", j), rdata_a[0], 16'h7000 + prev_a);
                end
            end
            if (j == 8) begin
                req_a[0] = 1'b0;
            end else begin
                prev_w = (j % 2 == 0);
                prev_a = 16'(j / 2);
                we_a[0] = prev_w;
                addr_a[0] = 16'h0200 + prev_a;
                wdata_a[0] = prev_w ? 16'h7000 + prev_a : 16'h0BAD ^ 16'(j);
                @(negedge clk);
                t = 1;
            end
        end
        @(negedge clk);

        // A req pulsed while a write is in flight must be dropped.
        req_a[0] = 1'b1; we_a[0] = 1'b1; addr_a[0] = 16'h0030; wdata_a[0] = 16'h3333;
        @(negedge clk);
        req_a[0] = 1'b1; addr_a[0] = 16'hFFFF; wdata_a[0] = 16'hDEAD;
        check("ready_low_in_flight", ready_a[0], 0);
        @(negedge clk);
        req_a[0] = 1'b0;
        t = 0;
        wait_ready(0, t);
        ce_low = 0;
        repeat (6) begin
            @(negedge clk);
            if (!ce_a[0]) ce_low++;
        end
        check("no_extra_access", ce_low, 0);
        check("mem_ffff_untouched", mem[0][16'hFFFF], 16'hA5A5);
        access(0, 1'b0, 16'hFFFF, 16'h0, 16'hA5A5);
        access(0, 1'b0, 16'h0030, 16'h0, 16'h3333);

        // Inputs changed right after acceptance must not reach the SRAM.
        req_a[0] = 1'b1; we_a[0] = 1'b1; addr_a[0] = 16'h0020; wdata_a[0] = 16'h1234;
        @(negedge clk);
        req_a[0] = 1'b0; addr_a[0] = 16'h0021; wdata_a[0] = 16'hBEEF;
        t = 0;
        wait_ready(0, t);
        access(0, 1'b0, 16'h0020, 16'h0, 16'h1234);
        access(0, 1'b0, 16'h0021, 16'h0, 16'h5A7B);

        // Reset asserted in the middle of the WE pulse.
        req_a[0] = 1'b1; we_a[0] = 1'b1; addr_a[0] = 16'h0040; wdata_a[0] = 16'h4444;
        @(negedge clk);
        req_a[0] = 1'b0;
        @(negedge clk);
        check("we_low_before_reset", wen_a[0], 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_we_n", wen_a[0], 1);
        check("rst_async_ce_n", ce_a[0], 1);
        check("rst_async_oe_n", oe_a[0], 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", ready_a[0], 1);
        check("post_rst_rdata", rdata_a[0], 16'h0000);
        check("post_rst_ce_n", ce_a[0], 1);

        // Extreme-parameter sweep.
        for (int k = 1; k < NI; k++) begin
            for (int i = 0; i < 16; i++) access(k, 1'b1, 16'h0100 + 16'(i), 16'h1000 + 16'(i), 16'h0);
            for (int i = 0; i < 16; i++) access(k, 1'b0, 16'h0100 + 16'(i), 16'h0, 16'h1000 + 16'(i));
        end

        // Random traffic against a scoreboard of written words.
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 24; i++) begin
                bit          w;
                logic [15:0] a, d, e;
                w = 1'($urandom_range(0, 1));
                a = 16'h0300 + 16'($urandom_range(0, 7));
                d = 16'($urandom);
                if (w) begin
                    sb[k * 65536 + int'(a)] = d;
                    access(k, 1'b1, a, d, 16'h0);
                end else begin
                    e = sb.exists(k * 65536 + int'(a)) ? sb[k * 65536 + int'(a)] : init_pat(a);
                    access(k, 1'b0, a, 16'h0, e);
                end
            end
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
